mux_wb_driver: RTL and testbench
================================

# mux_wb_driver

Wishbone responder that lets the management core drive the multiplexed user designs in place of the IO pads. It owns the design-select, input and reset lines going to the mux, reads the muxed design output back, and provides a cycle-counted sample engine so firmware can capture `out` exactly N clocks after an event. It sits between the Caravel Wishbone bus and the mux bank, in parallel with the pad path, which remains selectable.

## Interface

Parameters:
- `SEL_BITS`, 6: width of the design-select bus (1..32).
- `INPUT_BITS`, 12: width of the design input bus (1..32).
- `OUTPUT_BITS`, 12: width of the design output bus (1..32).
- `BASE_ADDR`, 32'h3000_0000: register window base, 32-byte aligned.

Ports:
- `clk` in 1: single clock for the block, bus and mux designs.
- `rst_n` in 1: synchronous, active-low reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each: Wishbone strobe, cycle and write enable.
- `wbs_sel_i` in 4: byte lane enables.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: acknowledge.
- `wbs_dat_o` out 32: read data.
- `pin_sel` in SEL_BITS: design select from pads.
- `pin_in` in INPUT_BITS: design inputs from pads.
- `out` in OUTPUT_BITS: muxed design output.
- `mux_sel` out SEL_BITS: design select to the mux.
- `mux_in` out INPUT_BITS: design inputs to the mux.
- `mux_rst_n` out 1: design reset to the mux.
- `irq` out 1: sample-done interrupt.

## Operation

Register map (offset = `adr[4:2]`*4; a hit requires `adr[31:5]==BASE_ADDR[31:5]`):
- 0x00 CTRL, RW, bits [2:0]:
  - bit0 SRC: 0 = pads, 1 = registers.
  - bit1 HOLD: 1 forces `mux_rst_n` low.
  - bit2 IRQ_EN.
- 0x04 SEL, RW, [SEL_BITS-1:0].
- 0x08 IN, RW, [INPUT_BITS-1:0].
- 0x0C OUT, RO: `out_q`, which is `out` registered every cycle.
- 0x10 SAMPLE, WO, [15:0] = N. Writing starts the sample engine. Reads return 0.
- 0x14 STATUS:
  - bit0 BUSY, RO.
  - bit1 DONE, sticky; write 1 to clear.
- 0x18 SAMPLE_DATA, RO: captured `out`.
- 0x1C: reserved. Reads return 0 and writes are ignored, but the access is still acknowledged.

Register behaviour:
- Unwritten and unused upper bits read 0.
- Byte lanes are honoured on CTRL, SEL, IN and SAMPLE. A lane with `wbs_sel_i[k]=0` leaves bits [8k+7:8k] unchanged.
- STATUS DONE clear looks at lane 0 only.

Output muxing (combinational from the registers):
- `mux_sel = SRC ? SEL : pin_sel`.
- `mux_in = SRC ? IN : pin_in`.
- `mux_rst_n = rst_n & ~HOLD`.

Sample engine (states IDLE and COUNT):
- IDLE: a SAMPLE write loads `cnt <= N` and moves to COUNT, setting BUSY=1.
- COUNT with `cnt != 0`: `cnt` decrements each cycle.
- COUNT with `cnt == 0`: SAMPLE_DATA is loaded from `out`, DONE is set to 1, and the engine returns to IDLE.
- A SAMPLE write while in COUNT reloads `cnt` with the new N and stays in COUNT. The earlier request is discarded.
- If a DONE clear and a DONE set land on the same edge, the set wins.
- `irq = DONE & IRQ_EN`, registered.

Reset:
- All registers, `cnt`, state, `out_q`, SAMPLE_DATA, `wbs_ack_o` and `irq` reset to 0.
- After reset, `mux_sel` and `mux_in` follow the pads, and `mux_rst_n` follows `rst_n`.
- Reset asserted mid-count aborts the sample with no capture and DONE=0.

## Timing

- Bus accept condition: `stb & cyc & hit & ~ack`. A request is accepted on the edge where this holds.
  - `wbs_ack_o` is high for exactly one cycle after acceptance, so latency is 1 cycle.
  - Back-to-back requests produce ack at most every other cycle.
- `wbs_dat_o` is registered and valid during the ack cycle. It is 0 whenever ack is low.
- A non-hit address produces no ack and leaves `wbs_dat_o` at 0.
- Writes update the register on the accept edge, so the new value appears on `mux_*` in the ack cycle.
- OUT read lags `out` by 1 cycle because it returns `out_q`.
- Sample timing: a SAMPLE write with value N accepted at edge E captures `out` at edge E+N+1.
  - BUSY is high from E to E+N+1, and DONE rises at E+N+1.
  - `irq` rises at E+N+2.
  - N=0 captures at E+1.
- If `stb` drops before ack, the request is ignored. The responder does not track the cycle.

## Test plan

- Reset, then read all eight offsets -> every read returns 0 and `mux_rst_n`=1 once reset is released. With `pin_sel`=5, `pin_in`=0xABC, `mux_sel`=5 and `mux_in`=0xABC.
- Write SEL=0x2A, IN=0x123, then CTRL=1 -> `mux_sel`=0x2A and `mux_in`=0x123 from the CTRL ack cycle. Write CTRL=0 -> outputs return to the pad values. An IN write with `wbs_sel_i`=4'b0010 and data 0xFF00 -> IN=0xF23.
- Drive `out` = cycle counter, enable IRQ_EN, write SAMPLE=10 at edge E -> SAMPLE_DATA holds the counter value at E+11, BUSY spans E..E+11, DONE=1 and `irq`=1 at E+12. Write STATUS=2 -> DONE and `irq` clear.
- SAMPLE=100, then SAMPLE=3 written 20 cycles later -> a single capture 4 cycles after the second write, with DONE set once. SAMPLE=0 -> capture on the next edge.
- Start SAMPLE=50 and assert `rst_n` low at count 20 -> BUSY=0, DONE=0, SAMPLE_DATA=0, and no `irq`.
- Access address BASE+0x40 -> no ack. Access 0x1C -> ack with data 0. Hold `stb` continuously -> acks alternate 1,0,1. CTRL HOLD=1 -> `mux_rst_n`=0 while `rst_n`=1.

Source files
------------

// File: rtl/mux_wb_driver.sv
// mux_wb_driver
// Wishbone responder letting the management core drive the multiplexed user
// designs instead of the IO pads, plus a cycle-counted sample engine that
// captures the muxed design output exactly N+1 clocks after a SAMPLE write.
//
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   wbs_*                 - Wishbone slave (strobe/cycle/we/sel/adr/dat/ack)
//   pin_sel, pin_in       - design select / inputs from the pads
//   out                   - muxed design output
//   mux_sel, mux_in       - design select / inputs driven to the mux
//   mux_rst_n             - design reset driven to the mux
//   irq                   - registered sample-done interrupt
//
// Register map (offset adr[4:2]*4):
//   0x00 CTRL {IRQ_EN,HOLD,SRC}  0x04 SEL   0x08 IN   0x0C OUT (RO)
//   0x10 SAMPLE (WO)  0x14 STATUS {DONE(w1c),BUSY}  0x18 SAMPLE_DATA  0x1C rsvd
module mux_wb_driver #(
  parameter int          SEL_BITS    = 6,
  parameter int          INPUT_BITS  = 12,
  parameter int          OUTPUT_BITS = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  input  logic [SEL_BITS-1:0]    pin_sel,
  input  logic [INPUT_BITS-1:0]  pin_in,
  input  logic [OUTPUT_BITS-1:0] out,
  output logic [SEL_BITS-1:0]    mux_sel,
  output logic [INPUT_BITS-1:0]  mux_in,
  output logic                   mux_rst_n,
  output logic                   irq
);

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  state_t                 state;
  logic [2:0]             ctrl;
  logic [SEL_BITS-1:0]    sel_r;
  logic [INPUT_BITS-1:0]  in_r;
  logic [15:0]            n_q;
  logic [15:0]            cnt;
  logic [OUTPUT_BITS-1:0] out_q;
  logic [OUTPUT_BITS-1:0] sample_data;
  logic                   done;

  logic        hit;
  logic        accept;
  logic        wr;
  logic        rd;
  logic [2:0]  offset;
  logic [31:0] old_w;
  logic [31:0] new_w;
  logic [31:0] rdata;
  logic        sample_wr;
  logic        done_set;
  logic        done_clr;
  logic        busy;

  always_comb begin
    hit       = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    accept    = wbs_stb_i & wbs_cyc_i & hit & ~wbs_ack_o;
    wr        = accept & wbs_we_i;
    rd        = accept & ~wbs_we_i;
    offset    = wbs_adr_i[4:2];
    busy      = (state == COUNT);
    sample_wr = wr && (offset == 3'd4);

    // Current value of the addressed writable register, so that disabled
    // byte lanes keep their old contents after the merge below.
    case (offset)
      3'd0:    old_w = {29'd0, ctrl};
      3'd1:    old_w = 32'(sel_r);
      3'd2:    old_w = 32'(in_r);
      3'd4:    old_w = {16'd0, n_q};
      default: old_w = '0;
    endcase

    new_w = old_w;
    for (int unsigned k = 0; k < 4; k++) begin
      if (wbs_sel_i[k]) new_w[8*k +: 8] = wbs_dat_i[8*k +: 8];
    end

    case (offset)
      3'd0:    rdata = {29'd0, ctrl};
      3'd1:    rdata = 32'(sel_r);
      3'd2:    rdata = 32'(in_r);
      3'd3:    rdata = 32'(out_q);
      3'd5:    rdata = {30'd0, done, busy};
      3'd6:    rdata = 32'(sample_data);
      default: rdata = '0;
    endcase

    // A reload on the same edge discards the expiring request, so no capture.
    done_set = busy && (cnt == 16'd0) && !sample_wr;
    done_clr = wr && (offset == 3'd5) && wbs_sel_i[0] && wbs_dat_i[1];
  end

  always_comb begin
    mux_sel   = ctrl[0] ? sel_r : pin_sel;
    mux_in    = ctrl[0] ? in_r  : pin_in;
    mux_rst_n = rst_n & ~ctrl[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ctrl        <= '0;
      sel_r       <= '0;
      in_r        <= '0;
      n_q         <= '0;
      cnt         <= '0;
      out_q       <= '0;
      sample_data <= '0;
      done        <= 1'b0;
      irq         <= 1'b0;
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= '0;
    end else begin
      wbs_ack_o <= accept;
      wbs_dat_o <= rd ? rdata : '0;
      out_q     <= out;
      irq       <= done & ctrl[2];

      if (wr) begin
        case (offset)
          3'd0:    ctrl  <= new_w[2:0];
          3'd1:    sel_r <= new_w[SEL_BITS-1:0];
          3'd2:    in_r  <= new_w[INPUT_BITS-1:0];
          3'd4:    n_q   <= new_w[15:0];
          default: ;
        endcase
      end

      if (sample_wr) begin
        cnt   <= new_w[15:0];
        state <= COUNT;
      end else if (state == COUNT) begin
        if (cnt != 16'd0) begin
          cnt <= cnt - 16'd1;
        end else begin
          sample_data <= out;
          state       <= IDLE;
        end
      end

      if (done_set)      done <= 1'b1;
      else if (done_clr) done <= 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, wbs_adr_i[1:0], new_w};

endmodule

// File: tb/tb_mux_wb_driver.sv
module tb_mux_wb_driver;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0, dat = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic [5:0]  pin_sel = 6'd5;
  logic [11:0] pin_in = 12'hABC;
  logic [11:0] out_sig;
  logic [5:0]  mux_sel;
  logic [11:0] mux_in;
  logic        mux_rst_n;
  logic        irq;

  int unsigned cyc_n = 0;
  logic        use_cnt = 1'b0;
  logic [11:0] out_static = '0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  assign out_sig = use_cnt ? cyc_n[11:0] : out_static;

  mux_wb_driver #(.SEL_BITS(6), .INPUT_BITS(12), .OUTPUT_BITS(12), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .pin_sel(pin_sel), .pin_in(pin_in), .out(out_sig),
    .mux_sel(mux_sel), .mux_in(mux_in), .mux_rst_n(mux_rst_n), .irq(irq)
  );

  // One bus access; returns in the ack cycle (or after a bounded wait).
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rdat, output bit acked);
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
    acked = 1'b0; rdat = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack) begin acked = 1'b1; rdat = dat_o; break; end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r; bit ok;
    bus(1'b1, BASE + off, d, s, r, ok);
  endtask

  task automatic wait_irq(input int bound, output int unsigned at);
    at = 0;
    for (int i = 0; i < bound; i++) begin
      if (irq === 1'b1) begin at = cyc_n; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] got, e; bit ok;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (mux_rst_n !== 1'b0) begin miscompares++; $display("FAIL rst_mux_rst_n_low got=%0b exp=0", mux_rst_n); end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (mux_rst_n !== 1'b1) begin miscompares++; $display("FAIL rst_mux_rst_n_high got=%0b exp=1", mux_rst_n); end
    vectors++;
    if (irq !== 1'b0 || ack !== 1'b0) begin miscompares++; $display("FAIL rst_irq_ack got=%0b%0b exp=00", irq, ack); end
    for (int o = 0; o < 8; o++) begin
      exp_q.push_back(32'h0);
      bus(1'b0, BASE + 32'(o * 4), '0, 4'hF, got, ok);
      e = exp_q.pop_front();
      vectors++;
      if (!ok || got !== e) begin miscompares++; $display("FAIL rst_read_%0h got=%h ack=%0b exp=%h", o * 4, got, ok, e); end
    end
    vectors++;
    if (mux_sel !== 6'd5 || mux_in !== 12'hABC) begin
      miscompares++; $display("FAIL rst_pads got=%h/%h exp=05/abc", mux_sel, mux_in);
    end
  endtask

  task automatic test_mux();
    logic [31:0] got, e; bit ok;
    wr(32'h04, 32'h2A, 4'hF);
    wr(32'h08, 32'h123, 4'hF);
    wr(32'h00, 32'h1, 4'hF);
    vectors++;
    if (mux_sel !== 6'h2A || mux_in !== 12'h123) begin
      miscompares++; $display("FAIL mux_regs got=%h/%h exp=2a/123", mux_sel, mux_in);
    end
    wr(32'h00, 32'h0, 4'hF);
    vectors++;
    if (mux_sel !== 6'd5 || mux_in !== 12'hABC) begin
      miscompares++; $display("FAIL mux_pads got=%h/%h exp=05/abc", mux_sel, mux_in);
    end
    wr(32'h08, 32'hFF00, 4'b0010);
    exp_q.push_back(32'hF23);
    bus(1'b0, BASE + 32'h08, '0, 4'hF, got, ok);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin miscompares++; $display("FAIL in_lanes got=%h exp=%h", got, e); end
    out_static = 12'h5A5;
    repeat (2) @(posedge clk);
    exp_q.push_back(32'h5A5);
    bus(1'b0, BASE + 32'h0C, '0, 4'hF, got, ok);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin miscompares++; $display("FAIL out_read got=%h exp=%h", got, e); end
    out_static = '0;
  endtask

  task automatic test_sample();
    logic [31:0] got, e; bit ok; int unsigned e0, at;
    use_cnt = 1'b1;
    wr(32'h00, 32'h4, 4'hF);
    wr(32'h10, 32'd10, 4'hF);
    e0 = cyc_n;
    exp_q.push_back(32'h1);
    bus(1'b0, BASE + 32'h14, '0, 4'hF, got, ok);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin miscompares++; $display("FAIL sample_busy got=%h exp=%h", got, e); end
    wait_irq(40, at);
    vectors++;
    if (at != e0 + 12) begin miscompares++; $display("FAIL sample_irq_edge got=%0d exp=%0d", at, e0 + 12); end
    exp_q.push_back(32'h2);
    bus(1'b0, BASE + 32'h14, '0, 4'hF, got, ok);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin miscompares++; $display("FAIL sample_done got=%h exp=%h", got, e); end
    exp_q.push_back(32'((e0 + 10) & 32'hFFF));
    bus(1'b0, BASE + 32'h18, '0, 4'hF, got, ok);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin miscompares++; $display("FAIL sample_data got=%h exp=%h", got, e); end
    wr(32'h14, 32'h2, 4'hF);
    exp_q.push_back(32'h0);
    bus(1'b0, BASE + 32'h14, '0, 4'hF, got, ok);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e || irq !== 1'b0) begin miscompares++; $display("FAIL done_clear got=%h irq=%0b exp=%h irq=0", got, irq, e); end
  endtask

  task automatic test_reload();
    logic [31:0] got, e; bit ok; int unsigned e1, e2, at; bit seen;
    wr(32'h10, 32'd100, 4'hF);
    e1 = cyc_n;
    repeat (17) @(posedge clk);
    wr(32'h10, 32'd3, 4'hF);
    e2 = cyc_n;
    wait_irq(30, at);
    vectors++;
    if (at != e2 + 5) begin miscompares++; $display("FAIL reload_irq_edge got=%0d exp=%0d", at, e2 + 5); end
    exp_q.push_back(32'((e2 + 3) & 32'hFFF));
    bus(1'b0, BASE + 32'h18, '0, 4'hF, got, ok);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin miscompares++; $display("FAIL reload_data got=%h exp=%h", got, e); end
    wr(32'h14, 32'h2, 4'h1);
    seen = 1'b0;
    @(posedge clk); #1;
    while (cyc_n < e1 + 115) begin
      if (irq === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL reload_single got=irq_again exp=no_irq"); end
    exp_q.push_back(32'h0);
    bus(1'b0, BASE + 32'h14, '0, 4'hF, got, ok);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin miscompares++; $display("FAIL reload_status got=%h exp=%h", got, e); end
    wr(32'h10, 32'd0, 4'hF);
    e1 = cyc_n;
    wait_irq(10, at);
    vectors++;
    if (at != e1 + 2) begin miscompares++; $display("FAIL n0_irq_edge got=%0d exp=%0d", at, e1 + 2); end
    exp_q.push_back(32'(e1 & 32'hFFF));
    bus(1'b0, BASE + 32'h18, '0, 4'hF, got, ok);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin miscompares++; $display("FAIL n0_data got=%h exp=%h", got, e); end
    wr(32'h14, 32'h2, 4'h1);
  endtask

  task automatic test_reset_abort();
    logic [31:0] got, e; bit seen; bit ok;
    wr(32'h10, 32'd50, 4'hF);
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wr(32'h00, 32'h4, 4'hF);
    exp_q.push_back(32'h0);
    bus(1'b0, BASE + 32'h14, '0, 4'hF, got, ok);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin miscompares++; $display("FAIL abort_status got=%h exp=%h", got, e); end
    exp_q.push_back(32'h0);
    bus(1'b0, BASE + 32'h18, '0, 4'hF, got, ok);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin miscompares++; $display("FAIL abort_data got=%h exp=%h", got, e); end
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (irq === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL abort_irq got=1 exp=0"); end
    wr(32'h00, 32'h0, 4'hF);
    use_cnt = 1'b0;
  endtask

  task automatic test_bus_edges();
    logic [31:0] got, e; bit ok;
    bus(1'b0, BASE + 32'h40, '0, 4'hF, got, ok);
    vectors++;
    if (ok || dat_o !== 32'h0) begin miscompares++; $display("FAIL miss_noack got=ack%0b/%h exp=ack0/0", ok, dat_o); end
    wr(32'h1C, 32'hFFFF_FFFF, 4'hF);
    exp_q.push_back(32'h0);
    bus(1'b0, BASE + 32'h1C, '0, 4'hF, got, ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || got !== e) begin miscompares++; $display("FAIL rsvd got=%h ack=%0b exp=%h ack=1", got, ok, e); end
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (ack !== ((i % 2) == 0)) begin miscompares++; $display("FAIL ack_alt[%0d] got=%0b exp=%0b", i, ack, (i % 2) == 0); end
    end
    stb = 1'b0; cyc = 1'b0;
    wr(32'h00, 32'h2, 4'hF);
    vectors++;
    if (mux_rst_n !== 1'b0 || rst_n !== 1'b1) begin miscompares++; $display("FAIL hold got=%0b exp=0", mux_rst_n); end
    wr(32'h00, 32'h0, 4'hF);
    vectors++;
    if (mux_rst_n !== 1'b1) begin miscompares++; $display("FAIL hold_release got=%0b exp=1", mux_rst_n); end
  endtask

  initial begin
    test_reset();
    test_mux();
    test_sample();
    test_reload();
    test_reset_abort();
    test_bus_edges();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
